// File: rtl/riscv_cpu_pkg.sv
// Shared CPU definitions: fetch FSM states and fetch-related constants.
package riscv_cpu_pkg;

    // Instruction-fetch controller states
    typedef enum logic [1:0] {
        BOOT    = 2'd0,
        REQ     = 2'd1,
        WAIT    = 2'd2,
        DISCARD = 2'd3
    } fetch_state_e;

    // addi x0, x0, 0
    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_BOOT_ADDR = 32'h0000_0000;

    // Force an address onto a 32-bit instruction boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_fetch_ctl.sv
// Instruction-fetch controller: owns the fetch PC, keeps one request in flight
// on the req/gnt/rvalid instruction bus, feeds IF/ID and handles branch redirects.
module if_fetch_ctl
    import riscv_cpu_pkg::*;
#(
    parameter logic [31:0] BOOT_ADDR = DEFAULT_BOOT_ADDR
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        stall_i,
    output logic        instr_req_o,
    output logic [31:0] instr_addr_o,
    input  logic        instr_gnt_i,
    input  logic        instr_rvalid_i,
    input  logic [31:0] instr_rdata_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] pc_o,
    output logic        flush_o
);

    fetch_state_e state_reg;
    fetch_state_e state_next;
    logic [31:0]  fetch_pc_reg;
    logic [31:0]  fetch_pc_next;
    logic         valid_reg;
    logic         valid_next;
    logic [31:0]  instr_reg;
    logic [31:0]  instr_next;
    logic [31:0]  pc_reg;
    logic [31:0]  pc_next;

    logic         out_free;
    logic         req_fire;
    logic         rsp_accept;

    // Request gating, handshake qualifiers and the combinational flush
    always_comb begin
        // A new request is only issued if its response is guaranteed a free
        // output register; that keeps the datapath free of any skid buffer.
        out_free     = !valid_reg || !stall_i;
        instr_req_o  = (state_reg == REQ) && out_free;
        instr_addr_o = fetch_pc_reg;
        req_fire     = instr_req_o && instr_gnt_i;
        rsp_accept   = (state_reg == WAIT) && instr_rvalid_i;
        flush_o      = branch_taken_i;
    end

    // Next-state logic, including redirect handling per current state
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            BOOT: begin
                state_next = REQ;
            end
            REQ: begin
                // A granted request that is being redirected still owes a response
                if (req_fire) begin
                    state_next = branch_taken_i ? DISCARD : WAIT;
                end
            end
            WAIT: begin
                if (instr_rvalid_i) begin
                    state_next = REQ;
                end else if (branch_taken_i) begin
                    state_next = DISCARD;
                end
            end
            DISCARD: begin
                if (instr_rvalid_i) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    // Fetch PC and output-register next values; redirect beats stall
    always_comb begin
        fetch_pc_next = fetch_pc_reg;
        valid_next    = valid_reg;
        instr_next    = instr_reg;
        pc_next       = pc_reg;
        if (branch_taken_i) begin
            fetch_pc_next = word_align(branch_target_i);
            valid_next    = 1'b0;
        end else if (rsp_accept) begin
            // 32-bit add wraps 0xFFFF_FFFC back to 0
            fetch_pc_next = fetch_pc_reg + 32'd4;
            valid_next    = 1'b1;
            instr_next    = instr_rdata_i;
            pc_next       = fetch_pc_reg;
        end else if (!stall_i) begin
            valid_next    = 1'b0;
        end
    end

    // State, PC and output registers; reset aborts any transaction at once
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_reg    <= BOOT;
            fetch_pc_reg <= BOOT_ADDR;
            valid_reg    <= 1'b0;
            instr_reg    <= NOP_INSTR;
            pc_reg       <= BOOT_ADDR;
        end else begin
            state_reg    <= state_next;
            fetch_pc_reg <= fetch_pc_next;
            valid_reg    <= valid_next;
            instr_reg    <= instr_next;
            pc_reg       <= pc_next;
        end
    end

    assign instr_valid_o = valid_reg;
    assign instr_o       = instr_reg;
    assign pc_o          = pc_reg;

endmodule

// File: tb/tb_if_fetch_ctl.sv
// Self-checking bench for if_fetch_ctl: scoreboard of expected PCs popped as
// IF/ID consumes instructions, plus per-scenario inline checks.
module tb_if_fetch_ctl;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_ni;
    logic        branch_taken_i;
    logic [31:0] branch_target_i;
    logic        stall_i;
    logic        instr_req_o;
    logic [31:0] instr_addr_o;
    logic        instr_gnt_i;
    logic        instr_rvalid_i;
    logic [31:0] instr_rdata_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] pc_o;
    logic        flush_o;

    int n_vec = 0;
    int n_err = 0;
    int n_consumed = 0;
    logic [31:0] exp_q[$];

    if_fetch_ctl dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .branch_taken_i  (branch_taken_i),
        .branch_target_i (branch_target_i),
        .stall_i         (stall_i),
        .instr_req_o     (instr_req_o),
        .instr_addr_o    (instr_addr_o),
        .instr_gnt_i     (instr_gnt_i),
        .instr_rvalid_i  (instr_rvalid_i),
        .instr_rdata_i   (instr_rdata_i),
        .instr_valid_o   (instr_valid_o),
        .instr_o         (instr_o),
        .pc_o            (pc_o),
        .flush_o         (flush_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor: an instruction is consumed when valid, not stalled, not squashed
    initial begin
        logic [31:0] exp_pc;
        forever begin
            @(negedge clk);
            if (rst_ni === 1'b1) begin
                n_vec++;
                if (flush_o !== branch_taken_i) begin
                    n_err++;
                    $display("FAIL flush: flush_o=%b required %b", flush_o, branch_taken_i);
                end
                if (instr_valid_o === 1'b1 && stall_i === 1'b0 && branch_taken_i === 1'b0) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected_instr: pc_o=%h instr_o=%h required no instruction", pc_o, instr_o);
                    end else begin
                        exp_pc = exp_q.pop_front();
                        n_consumed++;
                        if (pc_o !== exp_pc || instr_o !== (exp_pc ^ K)) begin
                            n_err++;
                            $display("FAIL consume: pc_o=%h instr_o=%h required pc %h instr %h",
                                     pc_o, instr_o, exp_pc, exp_pc ^ K);
                        end else begin
                            $display("instr pc=%h instr=%h", pc_o, instr_o);
                        end
                    end
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time exceeded, required finish");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Hold reset for two edges, check reset values, release just after an edge
    task automatic do_reset();
        rst_ni = 1'b0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
        branch_taken_i = 1'b0; branch_target_i = 32'h0; stall_i = 1'b0;
        exp_q.delete();
        n_consumed = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0 || instr_valid_o !== 1'b0 ||
            instr_o !== NOP || pc_o !== 32'h0 || flush_o !== 1'b0) begin
            n_err++;
            $display("FAIL reset: req=%b addr=%h valid=%b instr=%h pc=%h flush=%b required 0 0 0 %h 0 0",
                     instr_req_o, instr_addr_o, instr_valid_o, instr_o, pc_o, flush_o, NOP);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    // One cycle of a zero-wait memory; returns what was seen in that cycle
    task automatic mem_step(output logic req, output logic [31:0] addr,
                            output logic val, output logic [31:0] pc, output logic [31:0] ins);
        logic        f;
        logic [31:0] a;
        @(negedge clk);
        req = instr_req_o; addr = instr_addr_o; val = instr_valid_o; pc = pc_o; ins = instr_o;
        f = instr_req_o && instr_gnt_i;
        a = instr_addr_o;
        @(posedge clk);
        #1;
        instr_gnt_i    = 1'b1;
        instr_rvalid_i = f;
        instr_rdata_i  = f ? (a ^ K) : 32'hDEAD_BEEF;
    endtask

    task automatic test_reset_stream();
        logic r, v, er, ev;
        logic [31:0] a, p, ins;
        do_reset();
        for (int k = 0; k < 5; k++) exp_q.push_back(32'(4 * k));
        for (int i = 0; i < 8; i++) begin
            mem_step(r, a, v, p, ins);
            er = (i % 2 == 1);
            ev = (i >= 3) && (i % 2 == 1);
            n_vec++;
            if (r !== er || (er && a !== 32'(2 * (i - 1)))) begin
                n_err++;
                $display("FAIL stream_req c%0d: req=%b addr=%h required req %b addr %h", i, r, a, er, 32'(2 * (i - 1)));
            end
            n_vec++;
            if (v !== ev || (ev && p !== 32'(2 * (i - 3)))) begin
                n_err++;
                $display("FAIL stream_valid c%0d: valid=%b pc=%h required valid %b pc %h", i, v, p, ev, 32'(2 * (i - 3)));
            end
        end
        n_vec++;
        if (n_consumed != 3) begin
            n_err++;
            $display("FAIL stream_count: consumed=%0d required 3", n_consumed);
        end
        exp_q.delete();
    endtask

    task automatic test_stall();
        logic r, v;
        logic [31:0] a, p, ins;
        do_reset();
        for (int k = 0; k < 6; k++) exp_q.push_back(32'(4 * k));
        for (int i = 0; i < 5; i++) mem_step(r, a, v, p, ins);
        stall_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            mem_step(r, a, v, p, ins);
            n_vec++;
            if (v !== 1'b1 || p !== 32'h4 || ins !== (32'h4 ^ K) || r !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold s%0d: valid=%b pc=%h instr=%h req=%b required 1 00000004 %h 0",
                         i, v, p, ins, r, 32'h4 ^ K);
            end
        end
        stall_i = 1'b0;
        mem_step(r, a, v, p, ins);
        n_vec++;
        if (r !== 1'b1 || a !== 32'h8) begin
            n_err++;
            $display("FAIL stall_release: req=%b addr=%h required 1 00000008", r, a);
        end
        for (int i = 0; i < 4; i++) mem_step(r, a, v, p, ins);
        n_vec++;
        if (n_consumed != 4 || exp_q.size() != 2) begin
            n_err++;
            $display("FAIL stall_count: consumed=%0d left=%0d required 4 2", n_consumed, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_branch_wait();
        do_reset();
        exp_q.push_back(32'h100);
        step(); instr_gnt_i = 1'b1;                          // cycle 1: REQ, granted
        step(); instr_gnt_i = 1'b0;                          // cycle 2: WAIT, redirect
        branch_taken_i = 1'b1; branch_target_i = 32'h100;
        @(negedge clk);
        n_vec++;
        if (flush_o !== 1'b1) begin
            n_err++; $display("FAIL bw_flush: flush_o=%b required 1", flush_o);
        end
        step(); branch_taken_i = 1'b0;                       // cycle 3: DISCARD
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b0) begin
            n_err++; $display("FAIL bw_discard_req: req=%b required 0", instr_req_o);
        end
        step(); instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0 ^ K;   // cycle 4: stale response
        step(); instr_rvalid_i = 1'b0; instr_gnt_i = 1'b1;          // cycle 5
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h100 || instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL bw_redirect: req=%b addr=%h valid=%b required 1 00000100 0",
                     instr_req_o, instr_addr_o, instr_valid_o);
        end
        step(); instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h100 ^ K;
        step(); instr_rvalid_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h100 || instr_o !== (32'h100 ^ K)) begin
            n_err++;
            $display("FAIL bw_output: valid=%b pc=%h instr=%h required 1 00000100 %h",
                     instr_valid_o, pc_o, instr_o, 32'h100 ^ K);
        end
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL bw_left: left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_branch_rvalid();
        do_reset();
        exp_q.push_back(32'h100);
        step(); instr_gnt_i = 1'b1;
        step(); instr_gnt_i = 1'b0;                          // WAIT with rvalid and redirect
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0 ^ K;
        branch_taken_i = 1'b1; branch_target_i = 32'h103;
        @(negedge clk);
        n_vec++;
        if (flush_o !== 1'b1) begin
            n_err++; $display("FAIL br_flush: flush_o=%b required 1", flush_o);
        end
        step(); instr_rvalid_i = 1'b0; branch_taken_i = 1'b0; instr_gnt_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (instr_valid_o !== 1'b0 || instr_req_o !== 1'b1 || instr_addr_o !== 32'h100) begin
            n_err++;
            $display("FAIL br_redirect: valid=%b req=%b addr=%h required 0 1 00000100",
                     instr_valid_o, instr_req_o, instr_addr_o);
        end
        step(); instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h100 ^ K;
        step(); instr_rvalid_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h100) begin
            n_err++;
            $display("FAIL br_output: valid=%b pc=%h required 1 00000100", instr_valid_o, pc_o);
        end
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL br_left: left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_double_branch();
        do_reset();
        exp_q.push_back(32'h300);
        step(); instr_gnt_i = 1'b1;
        step(); instr_gnt_i = 1'b0;                          // WAIT: first redirect
        branch_taken_i = 1'b1; branch_target_i = 32'h200;
        step(); branch_target_i = 32'h300;                   // DISCARD: second redirect
        @(negedge clk);
        n_vec++;
        if (flush_o !== 1'b1 || instr_req_o !== 1'b0) begin
            n_err++;
            $display("FAIL db_second: flush=%b req=%b required 1 0", flush_o, instr_req_o);
        end
        step(); branch_taken_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0 ^ K;
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b0) begin
            n_err++; $display("FAIL db_discard: req=%b required 0", instr_req_o);
        end
        step(); instr_rvalid_i = 1'b0; instr_gnt_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h300 || instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL db_redirect: req=%b addr=%h valid=%b required 1 00000300 0",
                     instr_req_o, instr_addr_o, instr_valid_o);
        end
        step(); instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h300 ^ K;
        step(); instr_rvalid_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h300) begin
            n_err++;
            $display("FAIL db_output: valid=%b pc=%h required 1 00000300", instr_valid_o, pc_o);
        end
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL db_left: left=%0d required 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        step(); instr_gnt_i = 1'b1;
        step(); instr_gnt_i = 1'b0;                          // WAIT, then reset mid-transaction
        rst_ni = 1'b0;
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b0 || instr_addr_o !== 32'h0 || instr_valid_o !== 1'b0 ||
            instr_o !== NOP || pc_o !== 32'h0 || flush_o !== 1'b0) begin
            n_err++;
            $display("FAIL rm_async: req=%b addr=%h valid=%b instr=%h pc=%h flush=%b required reset values",
                     instr_req_o, instr_addr_o, instr_valid_o, instr_o, pc_o, flush_o);
        end
        exp_q.push_back(32'h0);
        step(); rst_ni = 1'b1;                               // BOOT with a late rvalid
        instr_rvalid_i = 1'b1; instr_rdata_i = 32'hBAD0_BAD0;
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rm_boot: req=%b valid=%b required 0 0", instr_req_o, instr_valid_o);
        end
        step();                                              // REQ, no grant, late rvalid again
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rm_req: req=%b addr=%h valid=%b required 1 00000000 0",
                     instr_req_o, instr_addr_o, instr_valid_o);
        end
        step(); instr_rvalid_i = 1'b0; instr_gnt_i = 1'b1;
        @(negedge clk);
        n_vec++;
        if (instr_req_o !== 1'b1 || instr_addr_o !== 32'h0 || instr_valid_o !== 1'b0) begin
            n_err++;
            $display("FAIL rm_ignored: req=%b addr=%h valid=%b required 1 00000000 0",
                     instr_req_o, instr_addr_o, instr_valid_o);
        end
        step(); instr_gnt_i = 1'b0; instr_rvalid_i = 1'b1; instr_rdata_i = 32'h0 ^ K;
        step(); instr_rvalid_i = 1'b0;
        @(negedge clk);
        n_vec++;
        if (instr_valid_o !== 1'b1 || pc_o !== 32'h0 || instr_o !== K) begin
            n_err++;
            $display("FAIL rm_output: valid=%b pc=%h instr=%h required 1 00000000 %h",
                     instr_valid_o, pc_o, instr_o, K);
        end
        step();
        n_vec++;
        if (exp_q.size() != 0) begin
            n_err++; $display("FAIL rm_left: left=%0d required 0", exp_q.size());
        end
    endtask

    initial begin
        rst_ni = 1'b0;
        instr_gnt_i = 1'b0; instr_rvalid_i = 1'b0; instr_rdata_i = 32'h0;
        branch_taken_i = 1'b0; branch_target_i = 32'h0; stall_i = 1'b0;
        test_reset_stream();
        test_stall();
        test_branch_wait();
        test_branch_rvalid();
        test_double_branch();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_fetch_ctl.md
# if_fetch_ctl

Instruction-fetch controller at the front of the pipeline, and the consumer of the MEM-stage branch decision. It owns the fetch PC and runs one outstanding request at a time on the instruction-memory req/gnt/rvalid interface. It presents fetched instructions to the IF/ID register. On a taken branch it redirects the PC, squashes younger pipeline state and discards any in-flight response.

## Interface
- BOOT_ADDR, 32'h0000_0000, fetch PC after reset.
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- branch_taken_i  in  1  redirect request from MEM-stage branch control.
- branch_target_i  in  32  redirect target.
- stall_i  in  1  IF/ID not accepting; hold the output.
- instr_req_o  out  1  fetch request.
- instr_addr_o  out  32  fetch address, word aligned.
- instr_gnt_i  in  1  request accepted.
- instr_rvalid_i  in  1  response valid, earliest 1 cycle after gnt.
- instr_rdata_i  in  32  response data.
- instr_valid_o  out  1  instr_o/pc_o hold a valid instruction.
- instr_o  out  32  fetched instruction.
- pc_o  out  32  address of instr_o.
- flush_o  out  1  squash IF/ID, ID/EX and EX/MEM registers.

## Operation
- Registers:
  - fetch_pc.
  - state.
  - Output register: instr_valid_o, instr_o, pc_o.
- States:
  - BOOT: one cycle after reset release. Always goes to REQ.
  - REQ: instr_req_o=1, instr_addr_o=fetch_pc. On gnt, go to WAIT.
  - WAIT: waiting for rvalid. On rvalid:
    - load the output register with rdata and fetch_pc;
    - fetch_pc += 4 (wraps 32'hFFFF_FFFC→0);
    - go to REQ.
  - DISCARD: drop the next rvalid, then go to REQ.
- Request gating: REQ asserts instr_req_o only when the output register will be free, i.e. !instr_valid_o || !stall_i. Otherwise it stays in REQ with instr_req_o=0.
- Output consumed: when !stall_i and no new data is loaded, instr_valid_o clears.
- Stall: instr_valid_o, instr_o and pc_o hold unchanged.
- Redirect (branch_taken_i=1), highest priority over stall:
  - flush_o=1 combinationally in the same cycle.
  - fetch_pc ← {branch_target_i[31:2],2'b00}.
  - instr_valid_o clears at the edge.
  - Next state by current state:
    - REQ without gnt: REQ. The next request carries the new address; retraction is legal on our memory.
    - REQ with gnt: DISCARD.
    - WAIT without rvalid: DISCARD.
    - WAIT with rvalid: data is dropped, next state REQ.
    - DISCARD without rvalid: stay DISCARD, target updated.
    - DISCARD with rvalid: REQ.
    - BOOT: REQ, with the new target.
- flush_o is 0 whenever branch_taken_i=0.
- instr_rdata_i is ignored outside WAIT.

## Timing
- Reset values:
  - fetch_pc=BOOT_ADDR, state=BOOT.
  - instr_req_o=0, instr_addr_o=BOOT_ADDR.
  - instr_valid_o=0, instr_o=32'h0000_0013 (NOP), pc_o=BOOT_ADDR.
  - flush_o=0.
- Reset mid-transaction aborts immediately. A late rvalid arriving after reset release, while in BOOT or REQ, is ignored.
- Latency with zero-wait memory (gnt same cycle as req, rvalid next cycle):
  - first req at cycle 1 after reset release;
  - first instr_valid_o at cycle 3;
  - steady-state throughput is 1 instruction per 2 cycles.
- Redirect-to-new-request: 1 cycle from REQ or WAIT. From DISCARD, 1 cycle after the discarded rvalid.
- Output register has no combinational path from instr_rdata_i. Outputs are registered, except flush_o and instr_req_o gating.

## Structure
- Shared package riscv_cpu_pkg gains:
  - fetch_state_e (BOOT, REQ, WAIT, DISCARD);
  - NOP_INSTR = 32'h0000_0013;
  - default BOOT_ADDR constant.
- Single module, no sub-module. The FSM, PC register and output register are small enough to live together.

## Test plan
- Reset, zero-wait memory, rdata=addr^32'hA5A5_0000 -> addresses 0x0,0x4,0x8 requested; instr_valid_o at cycles 3,5,7 with pc_o 0x0,0x4,0x8.
- stall_i high 4 cycles while instr_valid_o=1 (pc_o=0x4) -> outputs frozen at 0x4, instr_req_o=0 after the next response is buffered, no instruction lost or duplicated after release.
- branch_taken_i with target 0x100 while in WAIT, rvalid 2 cycles later -> flush_o=1 that cycle, stale response dropped, next request addr 0x100, next pc_o 0x100.
- branch_taken_i in the same cycle as rvalid, target 0x103 -> data dropped, next request addr 0x100.
- Two taken branches (0x200 then 0x300) while in DISCARD -> single discard, next request 0x300.
- rst_ni low mid-WAIT, late rvalid after release -> all outputs at reset values, late rvalid ignored, first request BOOT_ADDR.
